// File: rtl/muacm_in_pkt.sv
// Byte FIFO and packetizer that drives the muacm IN port. A packet ends on the size limit,
// on s_flush_i, or after an idle timeout. Write-to-read latency is one cycle; s_ready_o drops while the FIFO is full.
module muacm_in_pkt #(
  parameter int DEPTH_LOG2   = 6,
  parameter int MAX_PKT      = 64,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] s_data_i,
  input  logic       s_valid_i,
  output logic       s_ready_o,
  input  logic       s_flush_i,
  output logic [7:0] in_data_o,
  output logic       in_last_o,
  output logic       in_valid_o,
  input  logic       in_ready_i,
  output logic       in_flush_now_o,
  output logic       in_flush_time_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;
  localparam int PW    = (MAX_PKT > 1) ? $clog2(MAX_PKT) : 1;
  localparam int IW    = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_e;

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]         level_q, level_d, flush_cnt_q, flush_cnt_d;
  logic [PW-1:0]         pkt_cnt_q, pkt_cnt_d;
  logic [IW-1:0]         idle_q, idle_d;
  state_e                state_q, state_d;
  logic                  flush_now_q, flush_now_d;
  logic                  wr, rd, idle_fire, flush_ev;

  assign wr              = s_valid_i & s_ready_o;
  assign rd              = in_valid_o & in_ready_i;
  assign s_ready_o       = (level_q != LW'(DEPTH));
  assign in_valid_o      = (level_q != '0);
  assign in_data_o       = in_valid_o ? mem_q[rd_ptr_q] : 8'h00;
  assign in_last_o       = in_valid_o & ((pkt_cnt_q == PW'(MAX_PKT - 1)) | (flush_cnt_q == LW'(1)));
  assign in_flush_now_o  = flush_now_q;
  assign in_flush_time_o = 1'b0;

  always_comb begin
    level_d     = level_q + LW'(wr) - LW'(rd);
    idle_fire   = (state_q == STREAM) && !wr && (idle_q == IW'(IDLE_TIMEOUT - 1));
    flush_ev    = s_flush_i | idle_fire;
    pkt_cnt_d   = pkt_cnt_q;
    flush_cnt_d = flush_cnt_q;
    flush_now_d = rd && in_last_o && (flush_cnt_q == LW'(1));
    idle_d      = idle_q;

    if (rd) begin
      pkt_cnt_d = in_last_o ? '0 : pkt_cnt_q + PW'(1);
    end

    if (flush_ev) begin
      flush_cnt_d = level_d;
      // Nothing left to mark with last: bytes already handed over need a core-side flush.
      if (level_d == '0 && pkt_cnt_d != '0) begin
        flush_now_d = 1'b1;
        pkt_cnt_d   = '0;
      end
    end else if (rd && flush_cnt_q != '0) begin
      flush_cnt_d = flush_cnt_q - LW'(1);
    end

    if (wr || level_q == '0) begin
      idle_d = '0;
    end else if (state_q == STREAM && idle_q != IW'(IDLE_TIMEOUT)) begin
      idle_d = idle_q + IW'(1);
    end

    if (flush_cnt_d != '0) begin
      state_d = DRAIN;
    end else if (level_d != '0) begin
      state_d = STREAM;
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr) begin
      mem_q[wr_ptr_q] <= s_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      flush_cnt_q <= '0;
      pkt_cnt_q   <= '0;
      idle_q      <= '0;
      state_q     <= IDLE;
      flush_now_q <= 1'b0;
    end else begin
      if (wr) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      if (rd) rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
      level_q     <= level_d;
      flush_cnt_q <= flush_cnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
      idle_q      <= idle_d;
      state_q     <= state_d;
      flush_now_q <= flush_now_d;
    end
  end

endmodule
